// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Sequences program loading into instructionMem and arbitrates its ports
//   between the host loader and CPU fetch. A start pulse samples load_len.
//   The host word stream is then written to addresses 0..len-1, and the read
//   port is handed to the CPU once loading has finished.
//
//   Optional feature macro: IMEM_LOAD_VERIFY_EN
//     When defined, every loaded word is read back after the load. The XOR of
//     the read-back data is compared against the XOR of the words that were
//     written. A mismatch sends the controller to ERROR instead of RUN.
//     When undefined, LOAD goes straight to RUN. In that build, error is only
//     raised for an oversized load_len.
//
//   Reset is asynchronous and active-low. It aborts any load in progress.

module imem_load_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              mem_wr,
    output logic [31:0]       mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Largest legal word count (the full memory depth) and a pointer-width one.
    localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_PTR   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef IMEM_LOAD_VERIFY_EN
        VERIFY,
`endif
        RUN,
        ERROR
    } stateT;

    stateT             state;
    logic [ADDR_W:0]   lenReg;
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   wptrInc;
    logic              hostReady;
    logic              memWr;
    logic [ADDR_W-1:0] memWaddr;
    logic [DATA_W-1:0] memWdata;
    logic [ADDR_W-1:0] rdAddrNarrow;
    logic              cpuStall;
    logic              busyReg;
    logic              doneReg;
    logic              errorReg;

`ifdef IMEM_LOAD_VERIFY_EN
    // Read-back bookkeeping. The cycle counter must run RD_LAT cycles past
    // the last address so that it catches the final returning word.
    localparam logic [ADDR_W+1:0] ONE_CNT   = {{(ADDR_W+1){1'b0}}, 1'b1};
    localparam logic [ADDR_W+1:0] RD_LAT_V  = (ADDR_W+2)'(RD_LAT);

    logic [DATA_W-1:0] chk;
    logic [DATA_W-1:0] vchk;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W+1:0] vcnt;
    logic [ADDR_W+1:0] lastCnt;
    logic [DATA_W-1:0] vchkFinal;

    assign lastCnt   = {1'b0, lenReg} + RD_LAT_V - ONE_CNT;
    assign vchkFinal = vchk ^ mem_rdata;
`endif

    assign wptrInc = wptr + ONE_PTR;

    // Read-port arbitration: the CPU owns the port in RUN. Otherwise the
    // controller drives it (read-back addresses during VERIFY, zero elsewhere).
    always_comb begin
        rdAddrNarrow = '0;
        if (state == RUN) begin
            rdAddrNarrow = cpu_pc;
        end
`ifdef IMEM_LOAD_VERIFY_EN
        else if (state == VERIFY) begin
            rdAddrNarrow = rptr[ADDR_W-1:0];
        end
`endif
    end

    assign mem_raddr  = {{(32-ADDR_W){1'b0}}, rdAddrNarrow};
    assign mem_waddr  = {{(32-ADDR_W){1'b0}}, memWaddr};
    assign mem_wdata  = memWdata;
    assign mem_wr     = memWr;
    assign host_ready = hostReady;
    assign cpu_instr  = mem_rdata;
    assign cpu_stall  = cpuStall;
    assign busy       = busyReg;
    assign done       = doneReg;
    assign error      = errorReg;

    // Main controller FSM. All outputs are registered here. The final write
    // lands in the extra LOAD cycle after the last handshake, so no write is
    // ever in flight once the CPU owns the memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lenReg    <= '0;
            wptr      <= '0;
            hostReady <= 1'b0;
            memWr     <= 1'b0;
            memWaddr  <= '0;
            memWdata  <= '0;
            cpuStall  <= 1'b1;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            errorReg  <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
            chk       <= '0;
            vchk      <= '0;
            rptr      <= '0;
            vcnt      <= '0;
`endif
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE, RUN, ERROR: begin
                    memWr <= 1'b0;
                    if (start) begin
                        lenReg   <= load_len;
                        wptr     <= '0;
                        errorReg <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
                        chk      <= '0;
`endif
                        if (load_len > DEPTH_LEN) begin
                            state    <= ERROR;
                            errorReg <= 1'b1;
                            cpuStall <= 1'b1;
                        end else if (load_len == '0) begin
                            state    <= RUN;
                            doneReg  <= 1'b1;
                            cpuStall <= 1'b0;
                        end else begin
                            state     <= LOAD;
                            hostReady <= 1'b1;
                            busyReg   <= 1'b1;
                            cpuStall  <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (wptr == lenReg) begin
                        memWr     <= 1'b0;
                        hostReady <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
                        state     <= VERIFY;
                        rptr      <= '0;
                        vcnt      <= '0;
                        vchk      <= '0;
`else
                        state     <= RUN;
                        busyReg   <= 1'b0;
                        doneReg   <= 1'b1;
                        cpuStall  <= 1'b0;
`endif
                    end else if (host_valid && hostReady) begin
                        memWr    <= 1'b1;
                        memWaddr <= wptr[ADDR_W-1:0];
                        memWdata <= host_data;
                        wptr     <= wptrInc;
`ifdef IMEM_LOAD_VERIFY_EN
                        chk      <= chk ^ host_data;
`endif
                        if (wptrInc == lenReg) begin
                            hostReady <= 1'b0;
                        end
                    end else begin
                        memWr <= 1'b0;
                    end
                end

`ifdef IMEM_LOAD_VERIFY_EN
                VERIFY: begin
                    memWr <= 1'b0;
                    vcnt  <= vcnt + ONE_CNT;
                    if (rptr != lenReg) begin
                        rptr <= rptr + ONE_PTR;
                    end
                    if (vcnt >= RD_LAT_V) begin
                        vchk <= vchkFinal;
                    end
                    if (vcnt == lastCnt) begin
                        busyReg <= 1'b0;
                        if (vchkFinal == chk) begin
                            state    <= RUN;
                            doneReg  <= 1'b1;
                            cpuStall <= 1'b0;
                        end else begin
                            state    <= ERROR;
                            errorReg <= 1'b1;
                            cpuStall <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl
//   Randomized bench for imem_load_ctrl with a behavioural instructionMem
//   (one-cycle read latency). The reference is simply "word i of the stream
//   lands at address i". Define IMEM_LOAD_VERIFY_EN for both files to
//   exercise the read-back path, including a corrupted-word scenario.

module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  load_len;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready;
    logic        mem_wr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [7:0]  cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem   [256];
    logic [31:0] refMem [256];
    logic [31:0] wrAddrs[$];
    int          doneCount = 0;
    int          wrWhileRun = 0;
    bit          corrupt3 = 1'b0;

    imem_load_ctrl #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .cpu_pc(cpu_pc),
        .cpu_instr(cpu_instr), .cpu_stall(cpu_stall), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Behavioural instructionMem: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_wr) begin
            imem[mem_waddr[7:0]] <= (corrupt3 && mem_waddr[7:0] == 8'd3) ? 32'hDEADBEEF : mem_wdata;
        end
        mem_rdata <= imem[mem_raddr[7:0]];
    end

    // Monitor on the falling edge: logs write addresses, done pulses and writes while the CPU runs.
    always @(negedge clk) begin
        if (mem_wr) begin
            wrAddrs.push_back(mem_waddr);
            if (!cpu_stall) wrWhileRun++;
        end
        if (done) doneCount++;
    end

    // Start a load, stream len random words, and wait for done or error.
    task automatic runLoad(input int len, input bit gaps, input bit pokeStart, output bit finished);
        int sent;
        int cyc;
        bit poked;
        logic [31:0] w;
        sent = 0; cyc = 0; poked = 0; finished = 0;
        wrAddrs.delete();
        start = 1'b1;
        load_len = 9'(len);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_stall_on_start: got %b want 1", cpu_stall);
        end
        while (sent < len && cyc < 4 * len + 20) begin
            start = 1'b0;
            if (pokeStart && !poked && sent == 2) begin
                start = 1'b1;
                load_len = 9'd1;
                poked = 1'b1;
            end
            w = $urandom;
            host_valid = gaps ? cyc[0] : 1'b1;
            host_data = w;
            if (host_valid && host_ready) begin
                refMem[sent] = w;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        host_valid = 1'b0;
        checks++;
        if (host_ready !== 1'b0 || sent != len) begin
            errors++;
            $display("[TB] FAIL ready_after_last: host_ready=%b sent=%0d want 0 and %0d", host_ready, sent, len);
        end
        cyc = 0;
        while (!done && !error && cyc < len + 20) begin
            @(negedge clk);
            cyc++;
        end
        finished = done || error;
        checks++;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL load_timeout: done=%b error=%b want a completion", done, error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; load_len = '0; host_valid = 1'b0;
        host_data = '0; cpu_pc = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({host_ready, mem_wr, cpu_stall, busy, done, error} !== 6'b001000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 001000", {host_ready, mem_wr, cpu_stall, busy, done, error});
        end
        checks++;
        if (mem_waddr !== 32'd0 || mem_wdata !== 32'd0 || mem_raddr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_addrs: waddr=%h wdata=%h raddr=%h want 0", mem_waddr, mem_wdata, mem_raddr);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        bit fin;
        int d0;
        logic [7:0] pc;
        d0 = doneCount;
        runLoad(17, 1'b0, 1'b0, fin);
        @(negedge clk);
        checks++;
        if (doneCount - d0 != 1) begin
            errors++;
            $display("[TB] FAIL basic_done_count: got %0d want 1", doneCount - d0);
        end
        checks++;
        if (cpu_stall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_run_flags: stall=%b busy=%b want 0 0", cpu_stall, busy);
        end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (imem[i] !== refMem[i]) begin
                errors++;
                $display("[TB] FAIL basic_mem[%0d]: got %h want %h", i, imem[i], refMem[i]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            pc = (k == 0) ? 8'd5 : 8'($urandom_range(0, 16));
            cpu_pc = pc;
            @(negedge clk);
            checks++;
            if (cpu_instr !== refMem[pc] || mem_raddr !== {24'd0, pc}) begin
                errors++;
                $display("[TB] FAIL fetch_pc%0d: instr=%h raddr=%h want %h", pc, cpu_instr, mem_raddr, refMem[pc]);
            end
        end
    endtask

    task automatic test_gapped_load();
        bit fin;
        int n;
        runLoad(4, 1'b1, 1'b0, fin);
        host_valid = 1'b1;
        host_data = $urandom;
        repeat (4) @(negedge clk);
        host_valid = 1'b0;
        n = wrAddrs.size();
        checks++;
        if (n != 4) begin
            errors++;
            $display("[TB] FAIL gapped_write_count: got %0d want 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (wrAddrs[i] !== 32'(i) || imem[i] !== refMem[i]) begin
                errors++;
                $display("[TB] FAIL gapped_write[%0d]: addr=%h data=%h want %h %h", i, wrAddrs[i], imem[i], i, refMem[i]);
            end
        end
    endtask

    task automatic test_bad_length();
        wrAddrs.delete();
        start = 1'b1; load_len = 9'd257;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({error, cpu_stall, host_ready, busy} !== 4'b1100 || wrAddrs.size() != 0) begin
            errors++;
            $display("[TB] FAIL bad_len_error: flags=%b writes=%0d want 1100 0", {error, cpu_stall, host_ready, busy}, wrAddrs.size());
        end
        start = 1'b1; load_len = 9'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({error, done, cpu_stall} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL zero_len_run: error,done,stall=%b want 010", {error, done, cpu_stall});
        end
    endtask

    task automatic test_abort_reset();
        int sent;
        int cyc;
        bit fin;
        int d0;
        start = 1'b1; load_len = 9'd17;
        @(negedge clk);
        start = 1'b0;
        sent = 0; cyc = 0;
        while (sent < 8 && cyc < 40) begin
            host_valid = 1'b1;
            host_data = $urandom;
            if (host_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        host_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({host_ready, mem_wr, cpu_stall, busy, done, error} !== 6'b001000 ||
            mem_waddr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL abort_reset_vals: flags=%b waddr=%h wdata=%h want 001000 0 0",
                     {host_ready, mem_wr, cpu_stall, busy, done, error}, mem_waddr, mem_wdata);
        end
        reset = 1'b1;
        @(negedge clk);
        d0 = doneCount;
        runLoad(17, 1'b0, 1'b0, fin);
        @(negedge clk);
        checks++;
        if (doneCount - d0 != 1 || wrAddrs.size() != 17) begin
            errors++;
            $display("[TB] FAIL abort_reload: done=%0d writes=%0d want 1 17", doneCount - d0, wrAddrs.size());
        end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (imem[i] !== refMem[i]) begin
                errors++;
                $display("[TB] FAIL abort_mem[%0d]: got %h want %h", i, imem[i], refMem[i]);
            end
        end
    endtask

    task automatic test_start_during_load();
        bit fin;
        int d0;
        d0 = doneCount;
        runLoad(6, 1'b0, 1'b1, fin);
        @(negedge clk);
        checks++;
        if (doneCount - d0 != 1 || wrAddrs.size() != 6) begin
            errors++;
            $display("[TB] FAIL midload_start: done=%0d writes=%0d want 1 6", doneCount - d0, wrAddrs.size());
        end
        checks++;
        if (imem[5] !== refMem[5]) begin
            errors++;
            $display("[TB] FAIL midload_last_word: got %h want %h", imem[5], refMem[5]);
        end
    endtask

    task automatic test_back_to_back();
        bit fin;
        int d0;
        d0 = doneCount;
        runLoad(2, 1'b0, 1'b0, fin);
        @(negedge clk);
        checks++;
        if (doneCount - d0 != 1 || cpu_stall !== 1'b0 || imem[1] !== refMem[1]) begin
            errors++;
            $display("[TB] FAIL reload_two: done=%0d stall=%b mem1=%h want 1 0 %h", doneCount - d0, cpu_stall, imem[1], refMem[1]);
        end
    endtask

    task automatic test_full_depth();
        bit fin;
        runLoad(256, 1'b0, 1'b0, fin);
        @(negedge clk);
        checks++;
        if (wrAddrs.size() != 256 || wrAddrs[255] !== 32'd255) begin
            errors++;
            $display("[TB] FAIL depth_writes: count=%0d want 256 ending at ff", wrAddrs.size());
        end
        checks++;
        if (imem[0] !== refMem[0] || imem[255] !== refMem[255]) begin
            errors++;
            $display("[TB] FAIL depth_mem: m0=%h m255=%h want %h %h", imem[0], imem[255], refMem[0], refMem[255]);
        end
        checks++;
        if (wrWhileRun != 0) begin
            errors++;
            $display("[TB] FAIL write_in_run: got %0d want 0", wrWhileRun);
        end
    endtask

`ifdef IMEM_LOAD_VERIFY_EN
    task automatic test_verify_corrupt();
        bit fin;
        int d0;
        d0 = doneCount;
        corrupt3 = 1'b1;
        runLoad(8, 1'b0, 1'b0, fin);
        corrupt3 = 1'b0;
        @(negedge clk);
        checks++;
        if ({error, cpu_stall, host_ready} !== 3'b110 || doneCount != d0) begin
            errors++;
            $display("[TB] FAIL verify_corrupt: err,stall,ready=%b done=%0d want 110 0", {error, cpu_stall, host_ready}, doneCount - d0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_bad_length();
        test_abort_reset();
        test_start_during_load();
        test_back_to_back();
        test_full_depth();
`ifdef IMEM_LOAD_VERIFY_EN
        test_verify_corrupt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
